// File: rtl/logic_unit_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | logic_unit_pipe_pkg                                                        |
// | Op-code encoding shared by the logic unit, its bench and future ALU blocks |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package logic_unit_pipe_pkg;

    typedef logic [2:0] op_t;

    // Codes 000..011 keep the meaning of the original 2-bit select.
    localparam op_t OP_XOR   = 3'b000;
    localparam op_t OP_XNOR  = 3'b001;
    localparam op_t OP_OR    = 3'b010;
    localparam op_t OP_NOR   = 3'b011;
    localparam op_t OP_AND   = 3'b100;
    localparam op_t OP_NAND  = 3'b101;
    localparam op_t OP_NOTA  = 3'b110;
    localparam op_t OP_PASSB = 3'b111;

endpackage : logic_unit_pipe_pkg
`default_nettype wire

// File: rtl/logic_unit_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | logic_unit_core                                                            |
// | Purely combinational 8-way bitwise function z = f(op, x, y)                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module logic_unit_core
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z
);

    always_comb begin
        z = '0;
        case (op)
            OP_XOR:   z = x ^ y;
            OP_XNOR:  z = ~(x ^ y);
            OP_OR:    z = x | y;
            OP_NOR:   z = ~(x | y);
            OP_AND:   z = x & y;
            OP_NAND:  z = ~(x & y);
            OP_NOTA:  z = ~x;
            OP_PASSB: z = y;
            default:  z = '0;
        endcase
    end

endmodule : logic_unit_core
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | logic_unit_pipe                                                            |
// | Registered bitwise unit with valid/ready, accumulator, flags and counter   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module logic_unit_pipe
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    input  logic             acc_mode,
    input  logic             acc_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ones,
    output logic             parity,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] r_result;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_zero;
    logic             r_ones;
    logic             r_parity;

    logic             w_accept;
    logic [WIDTH-1:0] w_eff_a;
    logic [WIDTH-1:0] w_z;

    // Ready depends only on the output register, so no in_valid->in_ready path.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_eff_a = a;
        if (acc_clear) begin
            w_eff_a = '0;
        end else if (acc_mode) begin
            w_eff_a = r_acc;
        end
    end

    logic_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op (op),
        .x  (w_eff_a),
        .y  (b),
        .z  (w_z)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_count     <= '0;
            r_zero      <= 1'b1;
            r_ones      <= 1'b0;
            r_parity    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_result    <= w_z;
                r_out_valid <= 1'b1;
                r_acc       <= w_z;
                r_count     <= r_count + CNT_W'(1);
                r_zero      <= (w_z == '0);
                r_ones      <= &w_z;
                r_parity    <= ^w_z;
            end else begin
                if (r_out_valid && out_ready) begin
                    r_out_valid <= 1'b0;
                end
                // A clear with no accept touches only the accumulator.
                if (acc_clear) begin
                    r_acc <= '0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign ones      = r_ones;
    assign parity    = r_parity;
    assign count     = r_count;

endmodule : logic_unit_pipe
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_logic_unit_pipe                                                         |
// | Directed scoreboard bench for logic_unit_pipe (8-bit, 4-bit count, 1-bit)  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_logic_unit_pipe;
    import logic_unit_pipe_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    op_t        op;
    logic       acc_mode;
    logic       acc_clear;
    logic       out_ready;

    logic        in_ready, out_valid, zero, ones, parity;
    logic [7:0]  result;
    logic [15:0] count;

    logic        in_ready4, out_valid4, zero4, ones4, parity4;
    logic [7:0]  result4;
    logic [3:0]  count4;

    logic        in_ready1, out_valid1, zero1, ones1, parity1;
    logic [0:0]  result1;
    logic [15:0] count1;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] m_acc;
    int         m_count;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .acc_mode(acc_mode), .acc_clear(acc_clear),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .ones(ones), .parity(parity), .count(count)
    );

    logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .op(op), .acc_mode(acc_mode), .acc_clear(acc_clear),
        .out_valid(out_valid4), .out_ready(out_ready), .result(result4),
        .zero(zero4), .ones(ones4), .parity(parity4), .count(count4)
    );

    logic_unit_pipe #(.WIDTH(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a[0:0]), .b(b[0:0]), .op(op), .acc_mode(acc_mode), .acc_clear(acc_clear),
        .out_valid(out_valid1), .out_ready(out_ready), .result(result1),
        .zero(zero1), .ones(ones1), .parity(parity1), .count(count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model(input op_t f, input logic [7:0] x, input logic [7:0] y);
        case (f)
            3'd0:    return x ^ y;
            3'd1:    return x ~^ y;
            3'd2:    return x | y;
            3'd3:    return ~(x | y);
            3'd4:    return x & y;
            3'd5:    return ~(x & y);
            3'd6:    return ~x;
            default: return y;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [7:0] e;
        logic       have;
        have = (exp_q.size() != 0);
        chk("out_valid",  32'(out_valid),  32'(have));
        chk("out_valid4", 32'(out_valid4), 32'(have));
        chk("out_valid1", 32'(out_valid1), 32'(have));
        chk("count",  32'(count),  32'(m_count[15:0]));
        chk("count4", 32'(count4), 32'(m_count[3:0]));
        chk("count1", 32'(count1), 32'(m_count[15:0]));
        if (have) begin
            e = exp_q[0];
            chk("result",  32'(result),  32'(e));
            chk("zero",    32'(zero),    32'(e == 8'h00));
            chk("ones",    32'(ones),    32'(e == 8'hFF));
            chk("parity",  32'(parity),  32'(^e));
            chk("result4", 32'(result4), 32'(e));
            chk("result1", 32'(result1), 32'(e[0]));
            chk("zero1",   32'(zero1),   32'(!e[0]));
            chk("ones1",   32'(ones1),   32'(e[0]));
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                        input op_t iop, input logic am, input logic ac, input logic rdy);
        logic       exp_rdy;
        logic       acc_now;
        logic [7:0] eff_a;
        logic [7:0] r;
        in_valid = v; a = ia; b = ib; op = iop;
        acc_mode = am; acc_clear = ac; out_ready = rdy;
        #1;
        exp_rdy = (exp_q.size() == 0) || rdy;
        chk("in_ready",  32'(in_ready),  32'(exp_rdy));
        chk("in_ready1", 32'(in_ready1), 32'(exp_rdy));
        acc_now = v && exp_rdy;
        eff_a   = ac ? 8'h00 : (am ? m_acc : ia);
        r       = model(iop, eff_a, ib);
        @(posedge clk);
        if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
        if (acc_now) begin
            exp_q.push_back(r);
            m_acc = r;
            m_count++;
        end else if (ac) begin
            m_acc = 8'h00;
        end
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic reset_check();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result",    32'(result),    32'd0);
        chk("rst_zero",      32'(zero),      32'd1);
        chk("rst_ones",      32'(ones),      32'd0);
        chk("rst_parity",    32'(parity),    32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
    endtask

    // Asserts reset between edges, checks it took effect at once, releases at a falling edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        reset_check();
        exp_q.delete();
        m_acc   = 8'h00;
        m_count = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = OP_XOR;
        acc_mode = 1'b0; acc_clear = 1'b0; out_ready = 1'b0;
        exp_q.delete(); m_acc = 8'h00; m_count = 0;
        #1;
        reset_check();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic function
        step(1, 8'hF0, 8'h3C, OP_XOR, 0, 0, 1);
        chk("s1_cc", 32'(result), 32'h0000_00CC);
        chk("s1_count", 32'(count), 32'd1);
        step(1, 8'h00, 8'h00, OP_NOR, 0, 0, 1);
        chk("s1_ff", 32'(result), 32'h0000_00FF);
        chk("s1_ones", 32'(ones), 32'd1);

        // Full op sweep, back to back
        for (int i = 0; i < 8; i++) step(1, 8'hA5, 8'h0F, op_t'(i), 0, 0, 1);
        step(0, 8'h00, 8'h00, OP_XOR, 0, 0, 1);

        // Backpressure
        do_reset();
        step(1, 8'h01, 8'h02, OP_OR, 0, 0, 0);
        step(1, 8'h04, 8'h08, OP_OR, 0, 0, 0);
        step(1, 8'h04, 8'h08, OP_OR, 0, 0, 0);
        chk("s3_held", 32'(result), 32'h0000_0003);
        step(1, 8'h04, 8'h08, OP_OR, 0, 0, 1);
        chk("s3_0c", 32'(result), 32'h0000_000C);
        chk("s3_count", 32'(count), 32'd2);
        step(0, 8'h00, 8'h00, OP_OR, 0, 0, 1);

        // Accumulator
        step(1, 8'h5A, 8'h01, OP_XOR, 1, 1, 1);
        chk("s4_01", 32'(result), 32'h0000_0001);
        step(1, 8'h5A, 8'h02, OP_XOR, 1, 0, 1);
        chk("s4_03", 32'(result), 32'h0000_0003);
        step(1, 8'h5A, 8'h04, OP_XOR, 1, 0, 1);
        chk("s4_07", 32'(result), 32'h0000_0007);
        step(0, 8'h5A, 8'h00, OP_XOR, 1, 1, 1);
        step(1, 8'h5A, 8'h80, OP_XOR, 1, 0, 1);
        chk("s4_80", 32'(result), 32'h0000_0080);
        step(0, 8'h00, 8'h00, OP_XOR, 0, 0, 1);

        // Reset while stalled with a pending result
        do_reset();
        step(1, 8'hF0, 8'h3C, OP_XOR, 0, 0, 0);
        chk("s5_stall_cc", 32'(result), 32'h0000_00CC);
        do_reset();
        step(1, 8'hF0, 8'h3C, OP_XOR, 0, 0, 1);
        chk("s5_again_cc", 32'(result), 32'h0000_00CC);
        chk("s5_again_count", 32'(count), 32'd1);

        // Counter wrap
        do_reset();
        for (int i = 0; i < 17; i++)
            step(1, 8'($urandom), 8'($urandom), op_t'($urandom_range(0, 7)), 0, 0, 1);
        chk("s6_count16", 32'(count), 32'd17);
        chk("s6_count4",  32'(count4), 32'd1);
        step(0, 8'h00, 8'h00, OP_XOR, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_logic_unit_pipe
`default_nettype wire
